// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-order FIFO of in-flight register writers. Raises a
// decode stall when an ID source depends on a writer that has not yet reached
// a stage forwarding can serve.
// Optional feature macro: SB_WB_BYPASS_EN. When defined, a match against the
// head entry that is retiring this cycle with the same rd is ignored, because
// MEM/WB forwarding supplies the value.

module hazard_scoreboard #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_valid,
  input  logic                   issue_regwrite,
  input  logic [4:0]             issue_rd,
  input  logic                   squash,
  input  logic                   wb_regwrite,
  input  logic [4:0]             wb_rd,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  input  logic                   id_use_rs1,
  input  logic                   id_use_rs2,
  output logic                   stall,
  output logic                   full,
  output logic                   empty,
  output logic                   err_overflow,
  output logic                   err_underflow,
  output logic                   err_order,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [4:0]             tagQ [DEPTH];
  logic [PtrW-1:0]        headQ, headD, tailQ, tailD, wrIdx;
  logic [CntW-1:0]        countQ, countD;
  logic [DEPTH-1:0]       entryValid;
  logic                   pushReq, popReq, wrEn;
  logic                   ovfSet, unfSet, ordSet;
  logic                   hit1, hit2, bypass1, bypass2;
  logic                   errOvfQ, errUnfQ, errOrdQ;
  logic [STALL_CNT_W-1:0] stallCyclesQ;

  assign pushReq = issue_valid & issue_regwrite & (issue_rd != 5'd0);
  assign popReq  = wb_regwrite & (wb_rd != 5'd0);

  assign full  = (countQ == CntW'(DEPTH));
  assign empty = (countQ == '0);

`ifdef SB_WB_BYPASS_EN
  assign bypass1 = popReq & (wb_rd == id_rs1);
  assign bypass2 = popReq & (wb_rd == id_rs2);
`else
  assign bypass1 = 1'b0;
  assign bypass2 = 1'b0;
`endif

  // An entry is valid when its distance from head is below the occupancy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entryValid[i] = (CntW'(PtrW'(i) - headQ) < countQ);
    end
  end

  // Compare both sources against every valid entry; bypassed head is skipped.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entryValid[i] && tagQ[i] == id_rs1 && !(bypass1 && PtrW'(i) == headQ)) hit1 = 1'b1;
      if (entryValid[i] && tagQ[i] == id_rs2 && !(bypass2 && PtrW'(i) == headQ)) hit2 = 1'b1;
    end
  end

  assign stall = (id_use_rs1 & (id_rs1 != 5'd0) & hit1) |
                 (id_use_rs2 & (id_rs2 != 5'd0) & hit2) |
                 (full & ~popReq);

  // Next-state: squash first, then pop, then push, each seeing the prior result.
  always_comb begin
    headD  = headQ;
    tailD  = tailQ;
    countD = countQ;
    wrEn   = 1'b0;
    wrIdx  = tailQ;
    ovfSet = 1'b0;
    unfSet = 1'b0;
    ordSet = 1'b0;
    if (squash) begin
      if (countD != '0) begin
        tailD  = tailD - 1'b1;
        countD = countD - 1'b1;
      end else begin
        unfSet = 1'b1;
      end
    end
    if (popReq) begin
      if (countQ == '0) begin
        unfSet = 1'b1;
      end else if (countD != '0) begin
        // A squash that took the only entry absorbs the pop silently.
        ordSet = (tagQ[headD] != wb_rd);
        headD  = headD + 1'b1;
        countD = countD - 1'b1;
      end
    end
    if (pushReq) begin
      if (countD == CntW'(DEPTH)) begin
        ovfSet = 1'b1;
      end else if (!stall) begin
        wrEn   = 1'b1;
        wrIdx  = tailD;
        tailD  = tailD + 1'b1;
        countD = countD + 1'b1;
      end
    end
  end

  // Pointer, occupancy, sticky error and stall counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      headQ        <= '0;
      tailQ        <= '0;
      countQ       <= '0;
      errOvfQ      <= 1'b0;
      errUnfQ      <= 1'b0;
      errOrdQ      <= 1'b0;
      stallCyclesQ <= '0;
    end else begin
      headQ   <= headD;
      tailQ   <= tailD;
      countQ  <= countD;
      errOvfQ <= errOvfQ | ovfSet;
      errUnfQ <= errUnfQ | unfSet;
      errOrdQ <= errOrdQ | ordSet;
      if (stall && stallCyclesQ != '1) stallCyclesQ <= stallCyclesQ + 1'b1;
    end
  end

  // Tag storage needs no reset; entries are qualified by occupancy.
  always_ff @(posedge clk) begin
    if (wrEn) tagQ[wrIdx] <= issue_rd;
  end

  assign err_overflow  = errOvfQ;
  assign err_underflow = errUnfQ;
  assign err_order     = errOrdQ;
  assign stall_cycles  = stallCyclesQ;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard. Expected values are hand-computed;
// the retire-cycle stall depends on whether SB_WB_BYPASS_EN is defined.

module tb_hazard_scoreboard;

`ifdef SB_WB_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_regwrite, squash, wb_regwrite;
  logic [4:0]  issue_rd, wb_rd, id_rs1, id_rs2;
  logic        id_use_rs1, id_use_rs2;
  logic        stall, full, empty, err_overflow, err_underflow, err_order;
  logic [15:0] stall_cycles;

  int nCompared   = 0;
  int nMismatched = 0;

  hazard_scoreboard #(.DEPTH(4), .STALL_CNT_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid   (issue_valid),
    .issue_regwrite(issue_regwrite),
    .issue_rd      (issue_rd),
    .squash        (squash),
    .wb_regwrite   (wb_regwrite),
    .wb_rd         (wb_rd),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_use_rs1    (id_use_rs1),
    .id_use_rs2    (id_use_rs2),
    .stall         (stall),
    .full          (full),
    .empty         (empty),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow),
    .err_order     (err_order),
    .stall_cycles  (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idleInputs();
    issue_valid = 0; issue_regwrite = 0; issue_rd = 0; squash = 0;
    wb_regwrite = 0; wb_rd = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    idleInputs();
    rst_n = 0;
    #7;
    rst_n = 1;
    #1;
  endtask

  // One cycle with an optional push and optional pop, then inputs return idle.
  task automatic cycle(input bit doPush, input logic [4:0] rd, input bit doPop,
                       input logic [4:0] wrd);
    issue_valid = doPush; issue_regwrite = doPush; issue_rd = rd;
    wb_regwrite = doPop; wb_rd = wrd;
    tick();
    issue_valid = 0; issue_regwrite = 0; issue_rd = 0; wb_regwrite = 0; wb_rd = 0;
  endtask

  initial begin
    // Power-on reset, then reset in the middle of traffic.
    doReset();
    checkEq("por_empty", empty, 1);
    checkEq("por_full", full, 0);
    cycle(1, 5'd1, 0, 0);
    cycle(1, 5'd2, 0, 0);
    cycle(1, 5'd3, 0, 0);
    id_rs1 = 5'd2; id_use_rs1 = 1; #1;
    checkEq("pre_rst_stall", stall, 1);
    tick();
    checkEq("pre_rst_cycles", stall_cycles, 1);
    rst_n = 0; #2;
    checkEq("in_rst_empty", empty, 1);
    checkEq("in_rst_stall", stall, 0);
    checkEq("in_rst_cycles", stall_cycles, 0);
    rst_n = 1;
    tick();
    checkEq("post_rst_empty", empty, 1);
    checkEq("post_rst_stall", stall, 0);
    checkEq("post_rst_cycles", stall_cycles, 0);
    checkEq("post_rst_errs", {err_overflow, err_underflow, err_order}, 0);

    // Dependency stall on rd=5 until its writeback.
    doReset();
    cycle(1, 5'd5, 0, 0);
    id_rs1 = 5'd5; id_use_rs1 = 1; #1;
    checkEq("dep_stall_a", stall, 1);
    tick();
    checkEq("dep_stall_b", stall, 1);
    checkEq("dep_cycles_b", stall_cycles, 1);
    tick();
    wb_regwrite = 1; wb_rd = 5'd5; #1;
    checkEq("dep_stall_retire", stall, Bypass ? 0 : 1);
    tick();
    wb_regwrite = 0; wb_rd = 0; #1;
    checkEq("dep_stall_after", stall, 0);
    checkEq("dep_empty_after", empty, 1);
    checkEq("dep_cycles", stall_cycles, Bypass ? 2 : 3);
    checkEq("dep_errs", {err_overflow, err_underflow, err_order}, 0);

    // x0 never recorded; unused sources never stall.
    doReset();
    cycle(1, 5'd0, 0, 0);
    checkEq("x0_no_entry", empty, 1);
    cycle(1, 5'd7, 0, 0);
    checkEq("r7_entry", empty, 0);
    id_rs2 = 5'd7; id_use_rs2 = 0; #1;
    checkEq("unused_rs2", stall, 0);
    id_use_rs2 = 1; #1;
    checkEq("used_rs2", stall, 1);
    id_use_rs2 = 0; id_rs1 = 5'd0; id_use_rs1 = 1; #1;
    checkEq("rs1_x0", stall, 0);
    id_use_rs1 = 0;

    // Full, simultaneous push+pop, overflow, then in-order drain.
    doReset();
    for (int k = 1; k <= 4; k++) cycle(1, 5'(k), 0, 0);
    checkEq("full_set", full, 1);
    checkEq("full_stall", stall, 1);
    issue_valid = 1; issue_regwrite = 1; issue_rd = 5'd5; wb_regwrite = 1; wb_rd = 5'd1; #1;
    checkEq("full_pushpop_nostall", stall, 0);
    cycle(1, 5'd5, 1, 5'd1);
    checkEq("full_after_pushpop", full, 1);
    checkEq("no_ovf_pushpop", err_overflow, 0);
    cycle(1, 5'd6, 0, 0);
    checkEq("ovf_set", err_overflow, 1);
    checkEq("ovf_full", full, 1);
    for (int k = 2; k <= 5; k++) cycle(0, 0, 1, 5'(k));
    checkEq("drain_empty", empty, 1);
    checkEq("drain_order", err_order, 0);
    checkEq("drain_unf", err_underflow, 0);
    checkEq("ovf_sticky", err_overflow, 1);

    // Ten entries streamed through to wrap the pointers.
    doReset();
    cycle(1, 5'd10, 0, 0);
    for (int k = 1; k < 10; k++) cycle(1, 5'(10 + k), 1, 5'(9 + k));
    checkEq("wrap_one_left", empty, 0);
    id_rs1 = 5'd19; id_use_rs1 = 1; #1;
    checkEq("wrap_tail_match", stall, 1);
    id_use_rs1 = 0;
    cycle(0, 0, 1, 5'd19);
    checkEq("wrap_empty", empty, 1);
    checkEq("wrap_order", err_order, 0);

    // Squash removes the youngest; squash+pop on one entry removes it once.
    doReset();
    cycle(1, 5'd8, 0, 0);
    cycle(1, 5'd9, 0, 0);
    squash = 1; tick(); squash = 0;
    id_rs1 = 5'd9; id_use_rs1 = 1; #1;
    checkEq("squash_9_gone", stall, 0);
    id_rs1 = 5'd8; #1;
    checkEq("squash_8_kept", stall, 1);
    id_use_rs1 = 0;
    squash = 1; cycle(0, 0, 1, 5'd8); squash = 0;
    checkEq("squash_pop_empty", empty, 1);
    checkEq("squash_pop_nounf", err_underflow, 0);

    // Underflow and order errors.
    doReset();
    cycle(0, 0, 1, 5'd4);
    checkEq("unf_set", err_underflow, 1);
    tick();
    checkEq("unf_sticky", err_underflow, 1);
    checkEq("unf_empty", empty, 1);
    cycle(1, 5'd6, 0, 0);
    cycle(0, 0, 1, 5'd3);
    checkEq("order_set", err_order, 1);
    checkEq("order_popped", empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
